// File: rtl/seyahat_uretici.sv
// seyahat_uretici -- travel-command generator.
//   Keeps an internal fuel tank that refuels on request. On a trip request it
//   issues one of four legal 6-bit route codes, using a valid/ready handshake,
//   but only when the tank is at or above the trip threshold. A request made
//   with low fuel is refused with a one-cycle reddet pulse.
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   istek         trip request (sampled in BOSTA only)
//   rota_sec[1:0] route index, sampled together with istek
//   dolum         refuel request (sampled in BOSTA only; istek has priority)
//   hazir         downstream ready
//   gecerli       command valid
//   rota[5:0]     route code, held stable while gecerli=1
//   yakit[3:0]    current tank level (registered)
//   reddet        one-cycle pulse: request refused because of low fuel
//   sefer_sayisi  accepted-trip counter, wraps 255->0
module seyahat_uretici #(
  parameter int unsigned YAKIT_ESIK    = 12,
  parameter int unsigned YAKIT_TUKETIM = 3,
  parameter int unsigned YAKIT_DOLUM   = 1,
  parameter int unsigned YAKIT_MAX     = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       istek,
  input  logic [1:0] rota_sec,
  input  logic       dolum,
  input  logic       hazir,
  output logic       gecerli,
  output logic [5:0] rota,
  output logic [3:0] yakit,
  output logic       reddet,
  output logic [7:0] sefer_sayisi
);

  localparam logic [0:0] BOSTA  = 1'b0;
  localparam logic [0:0] GONDER = 1'b1;

  localparam logic [3:0] ESIK_4    = 4'(YAKIT_ESIK);
  localparam logic [3:0] TUKETIM_4 = 4'(YAKIT_TUKETIM);
  localparam logic [4:0] DOLUM_5   = 5'(YAKIT_DOLUM);
  localparam logic [4:0] MAX_5     = 5'(YAKIT_MAX);

  logic [0:0] state_q,   state_d;
  logic [3:0] tank_q,    tank_d;
  logic       gecerli_q, gecerli_d;
  logic [5:0] rota_q,    rota_d;
  logic       reddet_q,  reddet_d;
  logic [7:0] sefer_q,   sefer_d;

  logic [5:0] rota_tablo;
  logic [4:0] dolum_toplam;

  always_comb begin
    rota_tablo = 6'b111000;
    case (rota_sec)
      2'd0: rota_tablo = 6'b111000;
      2'd1: rota_tablo = 6'b100011;
      2'd2: rota_tablo = 6'b100101;
      2'd3: rota_tablo = 6'b100110;
      default: rota_tablo = 6'b111000;
    endcase
  end

  // Refuel sum is one bit wider so saturation at YAKIT_MAX cannot be missed
  // through a 4-bit wrap.
  assign dolum_toplam = {1'b0, tank_q} + DOLUM_5;

  always_comb begin
    state_d   = state_q;
    tank_d    = tank_q;
    gecerli_d = gecerli_q;
    rota_d    = rota_q;
    reddet_d  = 1'b0;
    sefer_d   = sefer_q;
    case (state_q)
      BOSTA: begin
        if (istek) begin
          if (tank_q >= ESIK_4) begin
            rota_d    = rota_tablo;
            gecerli_d = 1'b1;
            state_d   = GONDER;
          end else begin
            reddet_d = 1'b1;
          end
        end else if (dolum) begin
          tank_d = (dolum_toplam > MAX_5) ? MAX_5[3:0] : dolum_toplam[3:0];
        end
      end
      GONDER: begin
        if (hazir) begin
          // Threshold >= consumption, so this subtraction cannot underflow.
          tank_d    = tank_q - TUKETIM_4;
          sefer_d   = sefer_q + 8'd1;
          gecerli_d = 1'b0;
          rota_d    = '0;
          state_d   = BOSTA;
        end
      end
      default: begin
        state_d   = BOSTA;
        gecerli_d = 1'b0;
        rota_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOSTA;
      tank_q    <= '0;
      gecerli_q <= 1'b0;
      rota_q    <= '0;
      reddet_q  <= 1'b0;
      sefer_q   <= '0;
    end else begin
      state_q   <= state_d;
      tank_q    <= tank_d;
      gecerli_q <= gecerli_d;
      rota_q    <= rota_d;
      reddet_q  <= reddet_d;
      sefer_q   <= sefer_d;
    end
  end

  assign gecerli      = gecerli_q;
  assign rota         = rota_q;
  assign yakit        = tank_q;
  assign reddet       = reddet_q;
  assign sefer_sayisi = sefer_q;

endmodule
